// File: rtl/memory_cycle_if.sv
// Memory bus between the memory stage (master) and the data memory (slave).
interface memory_cycle_if;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage of the pipeline: latches the execute-stage results, runs
// LOAD/STORE accesses on the memory bus (stalling upstream until ack),
// selects write-back data and resolves branches.
// Optional feature: define MEM_TIMEOUT_EN to abort an access after 16
// cycles without ack, flagging a sticky mem_err.
module memory_cycle (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           aluout,
   input  logic [15:0]           bout,
   input  logic [3:0]            rdout,
   input  logic [3:0]            op,
   input  logic                  zero,
   input  logic                  pos,
   input  logic                  regwrite,
   input  logic                  execute_pcwrite,
   memory_cycle_if.master        mem,
   output logic [15:0]           forwarded_aluout,
   output logic [15:0]           wbdata,
   output logic [3:0]            rdout_m,
   output logic [3:0]            opout_m,
   output logic                  regwriteout,
   output logic                  branch_taken,
   output logic                  stall,
   output logic                  mem_err
);

   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_BEQ   = 4'hA;
   localparam logic [3:0] OP_BGT   = 4'hB;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] aluout_q, aluout_d;
   logic [15:0] bout_q, bout_d;
   logic [3:0]  rd_q, rd_d;
   logic [3:0]  op_q, op_d;
   logic        zero_q, zero_d;
   logic        pos_q, pos_d;
   logic        regwrite_q, regwrite_d;
   logic        pcwrite_q, pcwrite_d;
   logic [15:0] load_q, load_d;

`ifdef MEM_TIMEOUT_EN
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        suppress_q, suppress_d;
`endif

   logic in_is_mem;
   assign in_is_mem = (op == OP_LOAD) || (op == OP_STORE);

   // Stage registers: capture new instruction whenever not stalled.
   always_comb begin
      aluout_d   = aluout_q;
      bout_d     = bout_q;
      rd_d       = rd_q;
      op_d       = op_q;
      zero_d     = zero_q;
      pos_d      = pos_q;
      regwrite_d = regwrite_q;
      pcwrite_d  = pcwrite_q;
      if (!stall) begin
         aluout_d   = aluout;
         bout_d     = bout;
         rd_d       = rdout;
         op_d       = op;
         zero_d     = zero;
         pos_d      = pos;
         regwrite_d = regwrite;
         pcwrite_d  = execute_pcwrite;
      end
   end

   // Access FSM: enter ACCESS on a captured LOAD/STORE, leave on ack (or timeout).
   always_comb begin
      state_d = state_q;
      load_d  = load_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
      suppress_d = suppress_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_TIMEOUT_EN
            // A new instruction is captured every IDLE cycle, so the
            // write-back suppression of an aborted access ends here.
            suppress_d = 1'b0;
            cnt_d      = 4'h0;
`endif
            if (in_is_mem) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (mem.mem_ack) begin
               state_d = IDLE;
               if (op_q == OP_LOAD) begin
                  load_d = mem.mem_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == 4'hF) begin
               state_d    = IDLE;
               load_d     = 16'h0000;
               suppress_d = 1'b1;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'h1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with asynchronous clear of every stored value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         aluout_q   <= 16'h0000;
         bout_q     <= 16'h0000;
         rd_q       <= 4'h0;
         op_q       <= 4'h0;
         zero_q     <= 1'b0;
         pos_q      <= 1'b0;
         regwrite_q <= 1'b0;
         pcwrite_q  <= 1'b0;
         load_q     <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= 4'h0;
         err_q      <= 1'b0;
         suppress_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         aluout_q   <= aluout_d;
         bout_q     <= bout_d;
         rd_q       <= rd_d;
         op_q       <= op_d;
         zero_q     <= zero_d;
         pos_q      <= pos_d;
         regwrite_q <= regwrite_d;
         pcwrite_q  <= pcwrite_d;
         load_q     <= load_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         suppress_q <= suppress_d;
`endif
      end
   end

   logic access;
   assign access = (state_q == ACCESS);

   assign stall          = access;
   assign mem.mem_req    = access;
   assign mem.mem_we     = access && (op_q == OP_STORE);
   assign mem.mem_addr   = access ? aluout_q : 16'h0000;
   assign mem.mem_wdata  = access ? bout_q : 16'h0000;

   assign forwarded_aluout = aluout_q;
   assign rdout_m          = rd_q;
   assign opout_m          = op_q;
   assign wbdata           = (op_q == OP_LOAD) ? load_q : aluout_q;

   assign branch_taken = pcwrite_q && (((op_q == OP_BEQ) && zero_q) ||
                                       ((op_q == OP_BGT) && pos_q));

`ifdef MEM_TIMEOUT_EN
   assign regwriteout = regwrite_q && !access && (op_q != OP_STORE) && !suppress_q;
   assign mem_err     = err_q;
`else
   assign regwriteout = regwrite_q && !access && (op_q != OP_STORE);
   assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: expected stage results are queued
// when an instruction is driven and compared when it reaches the outputs.
module tb_memory_cycle;

   logic        clk;
   logic        rst;
   logic [15:0] aluout;
   logic [15:0] bout;
   logic [3:0]  rdout;
   logic [3:0]  op;
   logic        zero;
   logic        pos;
   logic        regwrite;
   logic        execute_pcwrite;
   logic [15:0] forwarded_aluout;
   logic [15:0] wbdata;
   logic [3:0]  rdout_m;
   logic [3:0]  opout_m;
   logic        regwriteout;
   logic        branch_taken;
   logic        stall;
   logic        mem_err;

   memory_cycle_if mif ();

   memory_cycle dut (
      .clk              (clk),
      .rst              (rst),
      .aluout           (aluout),
      .bout             (bout),
      .rdout            (rdout),
      .op               (op),
      .zero             (zero),
      .pos              (pos),
      .regwrite         (regwrite),
      .execute_pcwrite  (execute_pcwrite),
      .mem              (mif),
      .forwarded_aluout (forwarded_aluout),
      .wbdata           (wbdata),
      .rdout_m          (rdout_m),
      .opout_m          (opout_m),
      .regwriteout      (regwriteout),
      .branch_taken     (branch_taken),
      .stall            (stall),
      .mem_err          (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] fwd;
      logic [15:0] wb;
      logic [3:0]  rd;
      logic [3:0]  op;
      logic        rw;
      logic        br;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input logic rw, input logic z, input logic p,
                        input logic pcw);
      op = o; aluout = a; bout = b; rdout = rd; regwrite = rw;
      zero = z; pos = p; execute_pcwrite = pcw;
   endtask

   // Compare the oldest queued expectation with the current stage outputs.
   task automatic pop_compare(input string tag);
      exp_t e;
      check_val({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_val({tag, "_wbdata"}, {16'd0, wbdata}, {16'd0, e.wb});
         check_val({tag, "_fwd"}, {16'd0, forwarded_aluout}, {16'd0, e.fwd});
         check_val({tag, "_rdout_m"}, {28'd0, rdout_m}, {28'd0, e.rd});
         check_val({tag, "_opout_m"}, {28'd0, opout_m}, {28'd0, e.op});
         check_val({tag, "_regwriteout"}, {31'd0, regwriteout}, {31'd0, e.rw});
         check_val({tag, "_branch"}, {31'd0, branch_taken}, {31'd0, e.br});
         check_val({tag, "_stall"}, {31'd0, stall}, 32'd0);
         check_val({tag, "_mem_req"}, {31'd0, mif.mem_req}, 32'd0);
      end
      $display("txn %s op=%h wb=%h rd=%0d rw=%0d br=%0d", tag, opout_m, wbdata,
               rdout_m, regwriteout, branch_taken);
   endtask

   // Non-memory instruction: result visible one edge after capture.
   task automatic alu_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [3:0] rd, input logic rw, input logic z,
                         input logic p, input logic pcw, input logic br);
      exp_t e;
      drive(o, a, 16'h5555, rd, rw, z, p, pcw);
      e.fwd = a; e.wb = a; e.rd = rd; e.op = o; e.rw = rw; e.br = br;
      sb.push_back(e);
      tick();
      pop_compare(tag);
   endtask

   // LOAD/STORE with ack after wait_cyc ACCESS cycles; garbage is driven
   // upstream during the stall and must not disturb the stage.
   task automatic mem_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rd, input int wait_cyc,
                         input logic [15:0] rdata);
      exp_t e;
      logic is_store;
      is_store = (o == 4'h9);
      drive(o, a, b, rd, 1'b1, 1'b0, 1'b0, 1'b0);
      e.fwd = a; e.wb = is_store ? a : rdata; e.rd = rd; e.op = o;
      e.rw = !is_store; e.br = 1'b0;
      sb.push_back(e);
      tick();
      drive(4'h1, 16'hFFFF, 16'hEEEE, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i <= wait_cyc; i++) begin
         check_val({tag, "_stall"}, {31'd0, stall}, 32'd1);
         check_val({tag, "_mem_req"}, {31'd0, mif.mem_req}, 32'd1);
         check_val({tag, "_mem_addr"}, {16'd0, mif.mem_addr}, {16'd0, a});
         check_val({tag, "_mem_we"}, {31'd0, mif.mem_we}, {31'd0, is_store});
         check_val({tag, "_mem_wdata"}, {16'd0, mif.mem_wdata}, {16'd0, b});
         check_val({tag, "_rw_pending"}, {31'd0, regwriteout}, 32'd0);
         check_val({tag, "_fwd_hold"}, {16'd0, forwarded_aluout}, {16'd0, a});
         if (i == wait_cyc) begin
            mif.mem_ack = 1'b1;
            mif.mem_rdata = rdata;
         end
         tick();
      end
      mif.mem_ack = 1'b0;
      mif.mem_rdata = 16'h0000;
      pop_compare(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = 16'h0000;
      drive(4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      check_val("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
      check_val("rst_wbdata", {16'd0, wbdata}, 32'd0);
      check_val("rst_regwriteout", {31'd0, regwriteout}, 32'd0);
      check_val("rst_mem_err", {31'd0, mem_err}, 32'd0);
      rst = 1'b0;

      // ALU ops, including an ack while IDLE which must be ignored
      alu_op("alu1", 4'h1, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      mif.mem_ack = 1'b1;
      alu_op("alu_ackidle", 4'h2, 16'hA5A5, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      mif.mem_ack = 1'b0;

      // Memory accesses
      mem_op("load_w2", 4'h8, 16'h0040, 16'h0000, 4'd5, 2, 16'hBEEF);
      mem_op("store_w0", 4'h9, 16'h0010, 16'hCAFE, 4'd2, 0, 16'h0000);
      mem_op("load_w0", 4'h8, 16'h0020, 16'h1111, 4'd9, 0, 16'h7E57);
      mem_op("load_b2b", 4'h8, 16'h0024, 16'h2222, 4'd4, 1, 16'h0F0F);

      // Branches
      alu_op("beq_taken", 4'hA, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      alu_op("beq_not", 4'hA, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      alu_op("bgt_taken", 4'hB, 16'h0002, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      alu_op("bgt_nopcw", 4'hB, 16'h0003, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      alu_op("alu_after_br", 4'h3, 16'h4321, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset during a pending LOAD
      drive(4'h8, 16'h0080, 16'h0000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_val("midrst_pre_req", {31'd0, mif.mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check_val("midrst_mem_req", {31'd0, mif.mem_req}, 32'd0);
      check_val("midrst_stall", {31'd0, stall}, 32'd0);
      check_val("midrst_fwd", {16'd0, forwarded_aluout}, 32'd0);
      check_val("midrst_rdout_m", {28'd0, rdout_m}, 32'd0);
      check_val("midrst_opout_m", {28'd0, opout_m}, 32'd0);
      check_val("midrst_regwriteout", {31'd0, regwriteout}, 32'd0);
      $display("txn midrst req=%0d stall=%0d", mif.mem_req, stall);
      tick();
      rst = 1'b0;
      alu_op("alu_post_rst", 4'h4, 16'h9876, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // LOAD that never receives an ack
      drive(4'h8, 16'h00C0, 16'h0000, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(4'h1, 16'h1111, 16'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         check_val("to_stall", {31'd0, stall}, 32'd1);
         tick();
      end
      check_val("to_stall_end", {31'd0, stall}, 32'd0);
      check_val("to_mem_err", {31'd0, mem_err}, 32'd1);
      check_val("to_regwriteout", {31'd0, regwriteout}, 32'd0);
      check_val("to_wbdata", {16'd0, wbdata}, 32'd0);
      tick();
      check_val("to_mem_err_sticky", {31'd0, mem_err}, 32'd1);
      $display("txn timeout stall=%0d mem_err=%0d", stall, mem_err);
`else
      for (int i = 0; i < 20; i++) begin
         check_val("noto_stall", {31'd0, stall}, 32'd1);
         tick();
      end
      check_val("noto_mem_err", {31'd0, mem_err}, 32'd0);
      $display("txn no_timeout stall=%0d mem_err=%0d", stall, mem_err);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      check_val("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs from execute stage: aluout in 16 (result/address), bout in 16 (store data), rdout in 4 (dest reg), op in 4 (opcode), zero in 1, pos in 1, regwrite in 1, execute_pcwrite in 1.
REQ-004 SHALL have memory ports: mem_req out 1, mem_we out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16, mem_ack in 1.
REQ-005 SHALL have outputs: forwarded_aluout out 16 (stage aluout, feeds execute mux), wbdata out 16, rdout_m out 4, opout_m out 4, regwriteout out 1, branch_taken out 1, stall out 1, mem_err out 1.

Function
REQ-006 SHALL hold stage registers aluout_q, bout_q, rd_q, op_q, zero_q, pos_q, regwrite_q, pcwrite_q; capture all on posedge clk when stall=0, hold when stall=1.
REQ-007 SHALL decode opcodes: 4'h8 = LOAD, 4'h9 = STORE, 4'hA = BEQ, 4'hB = BGT; all others = ALU ops.
REQ-008 SHALL implement FSM states IDLE and ACCESS; IDLE->ACCESS on a capture whose op is LOAD or STORE; ACCESS->IDLE on the cycle mem_ack=1 is sampled.
REQ-009 SHALL drive stall = (state==ACCESS), combinationally.
REQ-010 SHALL drive mem_req=1 only in ACCESS; mem_addr=aluout_q, mem_wdata=bout_q, mem_we=1 only for STORE in ACCESS; all memory outputs 0 outside ACCESS.
REQ-011 SHALL register mem_rdata into load_q on the ACCESS cycle where mem_ack=1 and op_q=LOAD.
REQ-012 SHALL drive wbdata = load_q for LOAD, aluout_q otherwise.
REQ-013 SHALL drive regwriteout = regwrite_q AND state==IDLE AND op_q!=STORE; regwriteout stays 0 throughout a pending access.
REQ-014 SHALL drive forwarded_aluout=aluout_q, rdout_m=rd_q, opout_m=op_q.
REQ-015 SHALL drive branch_taken = pcwrite_q AND ((op_q==BEQ AND zero_q) OR (op_q==BGT AND pos_q)).
REQ-016 ALU op latency: inputs at edge N visible on outputs after edge N, no stall.
REQ-017 LOAD latency: with ack sampled k cycles after entry to ACCESS (k>=0), stall=1 for k+1 cycles; wbdata valid and regwriteout asserted in the first IDLE cycle.
REQ-018 mem_ack while IDLE SHALL be ignored.
REQ-019 Inputs presented while stall=1 SHALL be ignored; upstream holds them.

Reset
REQ-020 On rst=1, immediately and asynchronously: all stage registers, load_q, state=IDLE, and every output = 0 (mem_req drops at once, even mid-ACCESS).
REQ-021 After rst release, first posedge with stall=0 captures inputs normally.

Configuration
REQ-022 Macro MEM_TIMEOUT_EN SHALL enable an access timeout.
REQ-023 With MEM_TIMEOUT_EN defined: 4-bit counter cleared on entry to ACCESS, incremented each ACCESS cycle without ack; when it would increment past 15 (16 cycles without ack), state->IDLE, load_q=16'h0000, regwriteout suppressed for that instruction, mem_err set sticky until rst.
REQ-024 Without MEM_TIMEOUT_EN: ACCESS waits indefinitely for mem_ack, no counter logic, mem_err tied 0.

Verification
REQ-025 ALU op: aluout=16'h1234, rd=3, regwrite=1, op=4'h1 -> next cycle wbdata=16'h1234, forwarded_aluout=16'h1234, rdout_m=3, regwriteout=1, stall=0.
REQ-026 LOAD: aluout=16'h0040, op=4'h8, rd=5, mem_ack after 2 wait cycles with mem_rdata=16'hBEEF -> mem_req=1, mem_addr=16'h0040 for 3 cycles, stall=1 for 3 cycles, then wbdata=16'hBEEF, regwriteout=1.
REQ-027 STORE: aluout=16'h0010, bout=16'hCAFE, op=4'h9, immediate ack -> one cycle mem_req=1, mem_we=1, mem_wdata=16'hCAFE, stall=1; regwriteout=0.
REQ-028 Branch: op=4'hA, zero=1, execute_pcwrite=1 -> branch_taken=1; same with zero=0 -> 0; op=4'hB, pos=1 -> 1.
REQ-029 Reset mid-ACCESS: assert rst during LOAD wait -> mem_req, stall, all outputs 0 same cycle; after release, ALU op completes normally.
REQ-030 With MEM_TIMEOUT_EN: LOAD, never ack -> after 16 ACCESS cycles state IDLE, mem_err=1 held, regwriteout=0; without macro stall remains 1.
